// File: rtl/jtframe_dump_trigger.sv
// Frame-based dump window trigger: opens on a start frame (or on the end of
// ROM download) and optionally closes on a stop frame.
module jtframe_dump_trigger #(
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned STOP_FRAME  = 0,
  parameter int unsigned LOADROM     = 0,
  parameter int unsigned MINCYC      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        downloading,
  output logic [31:0] frame_cnt,
  output logic        dump_en,
  output logic        dump_start,
  output logic        dump_stop,
  output logic [1:0]  st
);

  localparam int unsigned FW = 32;
  localparam int unsigned CW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DUMPING = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          st_q;
  state_t          st_nx;
  logic            vs_l;
  logic            dl_l;
  logic            vs_fall;
  logic            dl_fall;
  logic [CW-1:0]   cyc_cnt;
  logic            start_hit;
  logic            stop_hit;
  logic            en_nx;
  logic            start_nx;
  logic            stop_nx;

  assign vs_fall = vs_l & ~vs;
  assign dl_fall = dl_l & ~downloading;
  assign st      = st_q;

  // Edge history, frame counter (download clear wins) and saturating cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_l      <= 1'b0;
      dl_l      <= 1'b0;
      frame_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      vs_l <= vs;
      dl_l <= downloading;
      if (downloading) begin
        frame_cnt <= '0;
      end else if (vs_fall) begin
        frame_cnt <= frame_cnt + FW'(1);
      end
      if (cyc_cnt != CW'(MINCYC)) begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
    end
  end

  // Window open/close conditions compare against the pre-increment frame count
  always_comb begin
    start_hit = 1'b0;
    if (LOADROM != 0) begin
      start_hit = dl_fall && (cyc_cnt == CW'(MINCYC));
    end else if (START_FRAME == 0) begin
      start_hit = 1'b1;
    end else begin
      start_hit = vs_fall && (frame_cnt == FW'(START_FRAME));
    end
    stop_hit = (STOP_FRAME != 0) && vs_fall && (frame_cnt == FW'(STOP_FRAME));
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
    end else begin
      st_q       <= st_nx;
      dump_en    <= en_nx;
      dump_start <= start_nx;
      dump_stop  <= stop_nx;
    end
  end

  // Next state
  always_comb begin
    st_nx = st_q;
    unique case (st_q)
      IDLE:    st_nx = ARMED;
      ARMED:   if (start_hit) st_nx = DUMPING;
      DUMPING: if (stop_hit) st_nx = DONE;
      default: st_nx = st_q;
    endcase
  end

  // Output values for the next cycle, so they line up with the registered state
  always_comb begin
    en_nx    = (st_nx == DUMPING);
    start_nx = (st_nx == DUMPING) && (st_q != DUMPING);
    stop_nx  = (st_nx == DONE) && (st_q != DONE);
  end

endmodule

// File: doc/jtframe_dump_trigger.md
JTFRAME_DUMP_TRIGGER -- requirements
Module: jtframe_dump_trigger

Interface
REQ-001 The block SHALL have parameter START_FRAME, default 0, the frame number that opens the dump window; 0 means open immediately.
REQ-002 The block SHALL have parameter STOP_FRAME, default 0, the frame number that closes the window; 0 means never close.
REQ-003 The block SHALL have parameter LOADROM, default 0; when 1, the window opens on the end of ROM download instead of on START_FRAME.
REQ-004 The block SHALL have parameter MINCYC, default 16, the number of clk cycles after reset during which download-end edges are ignored.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port vs, input, 1: vertical sync, synchronous to clk; a frame ends on its falling edge.
REQ-009 Port downloading, input, 1: high while ROM download is in progress.
REQ-010 Port frame_cnt, output, 32: count of vs falling edges seen.
REQ-011 Port dump_en, output, 1: high while the dump window is open.
REQ-012 Port dump_start, output, 1: one-cycle pulse when the window opens.
REQ-013 Port dump_stop, output, 1: one-cycle pulse when the window closes.
REQ-014 Port st, output, 2: current state, encoded IDLE=0, ARMED=1, DUMPING=2, DONE=3.

Function
REQ-015 The block SHALL register vs and downloading each cycle (vs_l, dl_l).
REQ-016 vs_fall SHALL be vs_l & ~vs; dl_fall SHALL be dl_l & ~downloading; both are valid from the second cycle after reset.
REQ-017 frame_cnt SHALL clear to 0 in any cycle where downloading is 1; that clear takes priority over increment.
REQ-018 Otherwise, frame_cnt SHALL increment by 1 on each vs_fall and wrap from 0xFFFFFFFF to 0.
REQ-019 A saturating cycle counter SHALL count clk cycles from reset up to MINCYC and hold at MINCYC.
REQ-020 The state machine SHALL go IDLE->ARMED unconditionally one cycle after reset release.
REQ-021 With LOADROM=0 and START_FRAME=0, ARMED->DUMPING SHALL occur on the first cycle spent in ARMED.
REQ-022 With LOADROM=0 and START_FRAME!=0, ARMED->DUMPING SHALL occur on a vs_fall where the pre-increment frame_cnt equals START_FRAME.
REQ-023 With LOADROM=1, ARMED->DUMPING SHALL occur on dl_fall only when the cycle counter equals MINCYC; an earlier dl_fall SHALL be ignored, with no retry until the next dl_fall.
REQ-024 DUMPING->DONE SHALL occur only when STOP_FRAME!=0, on a vs_fall where the pre-increment frame_cnt equals STOP_FRAME.
REQ-025 DONE SHALL be terminal until reset.
REQ-026 Stop comparisons SHALL be evaluated only in DUMPING, and at most one transition SHALL occur per cycle.
REQ-027 If STOP_FRAME <= START_FRAME, the window SHALL close only after frame_cnt wraps; this is defined behaviour.
REQ-028 dump_en SHALL be a registered output equal to (st==DUMPING).
REQ-029 dump_start SHALL assert in the same cycle that st first reads DUMPING.
REQ-030 dump_stop SHALL assert in the same cycle that st first reads DONE.
REQ-031 downloading activity in DUMPING or DONE SHALL clear frame_cnt only and SHALL NOT change state.

Reset
REQ-032 While rst=1, all of the following SHALL be 0: frame_cnt, dump_en, dump_start, dump_stop, st (IDLE), the cycle counter, vs_l and dl_l.
REQ-033 rst asserted mid-window SHALL drop dump_en immediately (asynchronously) without issuing a dump_stop pulse.
REQ-034 After rst deasserts, the sequence SHALL restart from IDLE.

Verification
REQ-035 Scenario: START_FRAME=0, LOADROM=0 -> st=1 at cycle 1 after reset, then dump_start and dump_en at cycle 2; dump_en stays 1 for 100 frames with no dump_stop.
REQ-036 Scenario: START_FRAME=5, STOP_FRAME=8, 10 vs pulses -> dump_start on the 6th vs_fall (frame_cnt 5->6); dump_stop on the 9th vs_fall; dump_en high for exactly 3 frames; final st=3.
REQ-037 Scenario: LOADROM=1, MINCYC=16, downloading falls at cycle 10 and again at cycle 40 -> no response at cycle 10; dump_start one cycle after the cycle-40 edge.
REQ-038 Scenario: downloading high for 3 vs pulses, then low -> frame_cnt stays 0 throughout, then counts 1, 2, 3 on subsequent vs_fall edges.
REQ-039 Scenario: frame_cnt preloaded by forcing to 0xFFFFFFFF, then one vs_fall -> frame_cnt=0 with no state change.
REQ-040 Scenario: rst pulsed while st=2 -> dump_en=0 in the same cycle, dump_stop never asserted, st returns to 2 per REQ-035 timing.
